// File: rtl/vedic_mult_pipe_if.sv
// Operand/product bus for the pipelined Vedic multiplier.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high on that channel. A producer holds valid and its payload until the
// transfer. in_ready never depends combinationally on in_valid. out_valid and
// out_product stay stable while out_valid=1 and out_ready=0.
interface vedic_mult_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  // Producer of operands / consumer of products
  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product
  );

  // The multiplier itself
  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/vedic_mult_pipe.sv
// 3-stage pipelined Urdhva-Tiryagbhyam multiplier, signed or unsigned per
// transaction. S1 registers sign and magnitudes, S2 registers the four half-width
// Vedic sub-products, S3 recombines, applies the sign and drives the output.
// A single global stall (output valid but not taken) freezes every stage.
module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  vedic_mult_pipe_if.slave bus
);

  localparam int H  = WIDTH / 2;   // half-operand width
  localparam int D  = H / 2;       // number of 2-bit digits in a half operand
  localparam int LV = $clog2(D);   // combine levels above the 2x2 base

  // 2x2 base: vertical (bit0*bit0, bit1*bit1) and crosswise terms
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic v0, c0, c1, v1, cr;
    v0 = x[0] & y[0];
    c0 = x[1] & y[0];
    c1 = x[0] & y[1];
    v1 = x[1] & y[1];
    cr = c0 & c1;
    return {v1 & cr, v1 ^ cr, c0 ^ c1, v0};
  endfunction

  // HxH Vedic product. The recursive split (lo*lo + (hi*lo + lo*hi) << n/2 +
  // hi*hi << n) is unrolled bottom-up: level 0 holds the 2x2 digit products,
  // each later level merges 2x2 blocks of the previous one.
  function automatic logic [2*H-1:0] vedic_hxh(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [2*H-1:0] cur [D][D];
    logic [2*H-1:0] nxt [D][D];
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        cur[i][j]      = '0;
        cur[i][j][3:0] = mul2(x[2*i +: 2], y[2*j +: 2]);
      end
    end
    for (int l = 0; l < LV; l++) begin
      nxt = cur;
      for (int i = 0; i < (D >> (l + 1)); i++) begin
        for (int j = 0; j < (D >> (l + 1)); j++) begin
          nxt[i][j] = cur[2*i][2*j]
                    + ((cur[2*i+1][2*j] + cur[2*i][2*j+1]) << (2 << l))
                    + (cur[2*i+1][2*j+1] << (4 << l));
        end
      end
      cur = nxt;
    end
    return cur[0][0];
  endfunction

  logic stall;

  logic               sg_in;
  logic [WIDTH-1:0]   ma_in, mb_in;

  logic               s1_valid, s1_sg;
  logic [WIDTH-1:0]   s1_ma, s1_mb;

  logic               s2_valid, s2_sg;
  logic [WIDTH-1:0]   s2_ll, s2_hl, s2_lh, s2_hh;

  logic               s3_valid;
  logic [2*WIDTH-1:0] s3_product;

  logic [2*WIDTH-1:0] p_sum;

  assign stall         = s3_valid & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = s3_valid;
  assign bus.out_product = s3_product;

  // Sign flag and operand magnitudes; -2^(WIDTH-1) negates to itself, which
  // read unsigned is the correct magnitude.
  always_comb begin
    sg_in = bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
    ma_in = (bus.in_signed && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
    mb_in = (bus.in_signed && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
  end

  // Recombine sub-products. The exact sum fits in 2*WIDTH bits, so computing
  // modulo 2^(2*WIDTH) loses nothing.
  always_comb begin
    p_sum = {{WIDTH{1'b0}}, s2_ll}
          + (({{WIDTH{1'b0}}, s2_hl} + {{WIDTH{1'b0}}, s2_lh}) << H)
          + {s2_hh, {WIDTH{1'b0}}};
  end

  // Pipeline registers: all stages advance together unless stalled; bubbles
  // move as invalid slots and data registers only load behind a valid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sg      <= 1'b0;
      s1_ma      <= '0;
      s1_mb      <= '0;
      s2_valid   <= 1'b0;
      s2_sg      <= 1'b0;
      s2_ll      <= '0;
      s2_hl      <= '0;
      s2_lh      <= '0;
      s2_hh      <= '0;
      s3_valid   <= 1'b0;
      s3_product <= '0;
    end else if (!stall) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sg <= sg_in;
        s1_ma <= ma_in;
        s1_mb <= mb_in;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sg <= s1_sg;
        s2_ll <= vedic_hxh(s1_ma[H-1:0],     s1_mb[H-1:0]);
        s2_hl <= vedic_hxh(s1_ma[WIDTH-1:H], s1_mb[H-1:0]);
        s2_lh <= vedic_hxh(s1_ma[H-1:0],     s1_mb[WIDTH-1:H]);
        s2_hh <= vedic_hxh(s1_ma[WIDTH-1:H], s1_mb[WIDTH-1:H]);
      end
      s3_valid <= s2_valid;
      if (s2_valid) begin
        // A zero magnitude negates to zero, so sign never corrupts 0
        s3_product <= s2_sg ? -p_sum : p_sum;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe: WIDTH=8 and WIDTH=16 instances, table vectors,
// random stream, stall, mid-stream reset and latency sequences.
module tb_vedic_mult_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vedic_mult_pipe_if #(.WIDTH(8))  b8 ();
  vedic_mult_pipe_if #(.WIDTH(16)) b16 ();

  vedic_mult_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  vedic_mult_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp8_q[$];
  logic [31:0] exp16_q[$];
  logic [15:0] exp8_next  = '0;
  logic [31:0] exp16_next = '0;
  logic [15:0] e8;
  logic [31:0] e16;
  int out8_cnt = 0, first8 = 0, last8 = 0;

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec8_t;
  vec8_t vt[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference product from plain integer multiplication
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    longint sa, sb, pr;
    logic [63:0] r;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    pr = sa * sb;
    r  = pr;
    return r & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // ---------------- monitors (sample mid low phase) ----------------
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (b8.out_valid && b8.out_ready) begin
        check("out8_expected_pending", exp8_q.size() > 0, 1);
        if (exp8_q.size() > 0) begin
          e8 = exp8_q.pop_front();
          check("out8_product", b8.out_product, e8);
        end
        out8_cnt++;
        if (out8_cnt == 1) first8 = cyc;
        last8 = cyc;
      end
      if (b8.in_valid && b8.in_ready) exp8_q.push_back(exp8_next);
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (b16.out_valid && b16.out_ready) begin
        check("out16_expected_pending", exp16_q.size() > 0, 1);
        if (exp16_q.size() > 0) begin
          e16 = exp16_q.pop_front();
          check("out16_product", b16.out_product, e16);
        end
      end
      if (b16.in_valid && b16.in_ready) exp16_q.push_back(exp16_next);
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    int budget;
    budget = 0;
    b8.in_valid = 1'b1; b8.in_signed = s; b8.in_a = a; b8.in_b = b; exp8_next = e;
    #1;
    while (!b8.in_ready && budget < 50) begin
      @(negedge clk); #1; budget++;
    end
    if (!b8.in_ready) check("send8_accept_timeout", b8.in_ready, 1);
    @(negedge clk);
    b8.in_valid = 1'b0;
  endtask

  task automatic send16(input logic s, input logic [15:0] a, input logic [15:0] b, input logic [31:0] e);
    int budget;
    budget = 0;
    b16.in_valid = 1'b1; b16.in_signed = s; b16.in_a = a; b16.in_b = b; exp16_next = e;
    #1;
    while (!b16.in_ready && budget < 50) begin
      @(negedge clk); #1; budget++;
    end
    if (!b16.in_ready) check("send16_accept_timeout", b16.in_ready, 1);
    @(negedge clk);
    b16.in_valid = 1'b0;
  endtask

  // Single op into an empty pipe: out_valid must rise on the 3rd edge counting the transfer edge
  task automatic lat8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    b8.in_valid = 1'b1; b8.in_signed = s; b8.in_a = a; b8.in_b = b; exp8_next = e;
    #1;
    check("lat8_in_ready", b8.in_ready, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) b8.in_valid = 1'b0;
      #1;
      check($sformatf("lat8_out_valid_edge%0d", k), b8.out_valid, (k == 3));
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while ((exp8_q.size() != 0 || exp16_q.size() != 0) && budget < 100) begin
      @(negedge clk); budget++;
    end
    check({name, "_q8_empty"},  exp8_q.size(),  0);
    check({name, "_q16_empty"}, exp16_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  logic [7:0]  ra, rb;
  logic        rs;
  logic [63:0] r;
  logic [15:0] hold;
  logic [15:0] corners[5];
  int          cnt0;

  initial begin
    vt[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vt[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vt[2]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vt[3]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vt[4]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vt[5]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
    vt[6]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
    vt[7]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vt[8]  = '{1'b1, 8'h80, 8'h01, 16'hFF80};
    vt[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vt[10] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
    vt[11] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vt[12] = '{1'b0, 8'h0F, 8'h10, 16'h00F0};
    vt[13] = '{1'b1, 8'h05, 8'hFD, 16'hFFF1};
    vt[14] = '{1'b0, 8'h7F, 8'hFF, 16'h7E81};
    vt[15] = '{1'b1, 8'hC0, 8'hC0, 16'h1000};
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    rst_n = 1'b0;
    b8.in_valid = 1'b0;  b8.in_signed = 1'b0;  b8.in_a = '0;  b8.in_b = '0;  b8.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_signed = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid8",    b8.out_valid,    0);
    check("rst_out_product8",  b8.out_product,  0);
    check("rst_out_valid16",   b16.out_valid,   0);
    check("rst_out_product16", b16.out_product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready8",  b8.in_ready,  1);
    check("rst_in_ready16", b16.in_ready, 1);
    @(negedge clk);

    // unsigned 0xFF*0xFF with latency measurement
    lat8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    drain("lat");

    // table vectors, back to back
    foreach (vt[i]) send8(vt[i].s, vt[i].a, vt[i].b, vt[i].p);
    drain("table");

    // random stream, mixed sign mode, continuous out_ready
    out8_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) ra = '0;
      rs = 1'($urandom_range(0, 1));
      r  = ref_mul(8, {24'd0, ra}, {24'd0, rb}, rs);
      send8(rs, ra, rb, r[15:0]);
    end
    drain("stream");
    check("stream_count", out8_cnt, 256);
    check("stream_one_per_cycle", last8 - first8, 255);

    // stall with 3 ops in flight
    cnt0 = out8_cnt;
    send8(1'b0, 8'h0B, 8'h0D, 16'h008F);
    send8(1'b1, 8'h90, 8'h03, 16'hFEB0);
    send8(1'b0, 8'hA5, 8'h5A, 16'h3A02);
    b8.out_ready = 1'b0;
    #1;
    check("stall_out_valid", b8.out_valid, 1);
    check("stall_in_ready",  b8.in_ready,  0);
    hold = b8.out_product;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("stall_hold_product", b8.out_product, hold);
      check("stall_hold_valid",   b8.out_valid,   1);
      check("stall_in_ready_low", b8.in_ready,    0);
    end
    b8.out_ready = 1'b1;
    @(negedge clk);
    drain("stall");
    check("stall_out_count", out8_cnt - cnt0, 3);

    // reset mid-stream: one op at the output, two in flight
    send8(1'b0, 8'h21, 8'h43, 16'h08A3);
    send8(1'b1, 8'hF0, 8'h10, 16'hFF00);
    send8(1'b0, 8'h33, 8'h33, 16'h0A29);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid",   b8.out_valid,   0);
    check("midrst_out_product", b8.out_product, 0);
    exp8_q.delete();
    exp16_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("postrst_no_stale", b8.out_valid, 0);
    end
    @(negedge clk);
    lat8(1'b1, 8'h80, 8'h01, 16'hFF80);
    drain("postrst");

    // WIDTH=16 corners in both modes
    send16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    send16(1'b1, 16'h8000, 16'h8000, 32'h40000000);
    send16(1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);
    send16(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
    for (int s = 0; s < 2; s++) begin
      foreach (corners[i]) begin
        foreach (corners[j]) begin
          r = ref_mul(16, {16'd0, corners[i]}, {16'd0, corners[j]}, 1'(s));
          send16(1'(s), corners[i], corners[j], r[31:0]);
        end
      end
    end
    drain("w16");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
